// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit slice.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

endpackage

// File: rtl/uart_tx_frame_if.sv
// Host-side handshake and serial output of the UART frame transmitter.
interface uart_tx_frame_if #(
  parameter int unsigned Width     = 15,
  parameter int unsigned DataWidth = 8
);

  logic [Width-1:0]     baud_i;
  logic                 start_i;
  logic [DataWidth-1:0] data_i;
  logic                 tx_o;
  logic                 busy_o;
  logic                 done_o;

  modport master (
    output baud_i, start_i, data_i,
    input  tx_o, busy_o, done_o
  );

  modport slave (
    input  baud_i, start_i, data_i,
    output tx_o, busy_o, done_o
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Restartable bit-period down-counter; ticks on the last cycle of each bit.
module uart_baud_tick #(
  parameter int unsigned Width = 15
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [Width-1:0] period_i,
  output logic             tick_o
);

  logic [Width-1:0] count_q;

  // Load restarts the period; otherwise count down and reload on expiry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= period_i;
    end else if (en_i) begin
      if (count_q == '0) begin
        count_q <= period_i;
      end else begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  assign tick_o = en_i && (count_q == '0);

endmodule

// File: rtl/uart_tx_frame.sv
// Serialises one byte into an RS-232 frame: start, data LSB first,
// optional parity, then one or two stop bits.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int unsigned Width     = 15,
  parameter int unsigned DataWidth = 8,
  parameter int unsigned Parity    = 0,
  parameter int unsigned StopBits  = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  uart_tx_frame_if.slave  bus
);

  localparam int unsigned       IdxW     = (DataWidth > 1) ? $clog2(DataWidth) : 1;
  localparam logic [IdxW-1:0]   LastIdx  = IdxW'(DataWidth - 1);
  localparam logic              LastStop = (StopBits == 2);
  localparam logic              OddPar   = (Parity == PARITY_ODD);

  tx_state_e            state_q;
  logic [DataWidth-1:0] shift_q;
  logic [DataWidth-1:0] data_q;
  logic [Width-1:0]     baud_q;
  logic [IdxW-1:0]      bit_idx_q;
  logic                 stop_cnt_q;
  logic                 tx_q;
  logic                 busy_q;
  logic                 done_q;

  logic                 tick;
  logic                 accept;
  logic [Width-1:0]     period;

  // A new frame is accepted from IDLE, or on the edge that ends the last
  // stop bit so consecutive frames abut; that edge loads the counter from
  // baud_i directly because baud_q is only updated by the same edge.
  always_comb begin
    accept = 1'b0;
    if (bus.start_i) begin
      if (state_q == IDLE) begin
        accept = 1'b1;
      end else if (state_q == STOP && tick && stop_cnt_q == LastStop) begin
        accept = 1'b1;
      end
    end
    period = accept ? bus.baud_i : baud_q;
  end

  uart_baud_tick #(
    .Width (Width)
  ) u_baud (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (accept),
    .en_i     (state_q != IDLE),
    .period_i (period),
    .tick_o   (tick)
  );

  // Frame FSM with shift register, bit index and registered line outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      data_q     <= '0;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        state_q    <= START;
        shift_q    <= bus.data_i;
        data_q     <= bus.data_i;
        baud_q     <= bus.baud_i;
        bit_idx_q  <= '0;
        stop_cnt_q <= 1'b0;
        tx_q       <= 1'b0;
        busy_q     <= 1'b1;
        if (state_q == STOP) begin
          done_q <= 1'b1;
        end
      end else if (tick) begin
        unique case (state_q)
          START: begin
            state_q   <= DATA;
            tx_q      <= shift_q[0];
            shift_q   <= shift_q >> 1;
            bit_idx_q <= '0;
          end
          DATA: begin
            if (bit_idx_q == LastIdx) begin
              if (Parity != PARITY_NONE) begin
                state_q <= PARITY;
                tx_q    <= (^data_q) ^ OddPar;
              end else begin
                state_q <= STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              tx_q      <= shift_q[0];
              shift_q   <= shift_q >> 1;
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end
          PARITY: begin
            state_q <= STOP;
            tx_q    <= 1'b1;
          end
          STOP: begin
            if (stop_cnt_q == LastStop) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              stop_cnt_q <= stop_cnt_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.tx_o   = tx_q;
  assign bus.busy_o = busy_q;
  assign bus.done_o = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench: four transmitter configurations share one stimulus
// and are compared against a frame-level reference model.
module tb_uart_tx_frame;

  localparam int PAR [4] = '{0, 1, 2, 0};
  localparam int STP [4] = '{1, 1, 1, 2};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  data = '0;
  logic [14:0] baud = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx_frame_if #(.Width(15), .DataWidth(8)) if0 ();
  uart_tx_frame_if #(.Width(15), .DataWidth(8)) if1 ();
  uart_tx_frame_if #(.Width(15), .DataWidth(8)) if2 ();
  uart_tx_frame_if #(.Width(15), .DataWidth(8)) if3 ();

  assign if0.start_i = start; assign if0.data_i = data; assign if0.baud_i = baud;
  assign if1.start_i = start; assign if1.data_i = data; assign if1.baud_i = baud;
  assign if2.start_i = start; assign if2.data_i = data; assign if2.baud_i = baud;
  assign if3.start_i = start; assign if3.data_i = data; assign if3.baud_i = baud;

  logic tx_a [4];
  logic busy_a [4];
  logic done_a [4];

  assign tx_a[0] = if0.tx_o; assign busy_a[0] = if0.busy_o; assign done_a[0] = if0.done_o;
  assign tx_a[1] = if1.tx_o; assign busy_a[1] = if1.busy_o; assign done_a[1] = if1.done_o;
  assign tx_a[2] = if2.tx_o; assign busy_a[2] = if2.busy_o; assign done_a[2] = if2.done_o;
  assign tx_a[3] = if3.tx_o; assign busy_a[3] = if3.busy_o; assign done_a[3] = if3.done_o;

  uart_tx_frame #(.Width(15), .DataWidth(8), .Parity(0), .StopBits(1))
    u0 (.clk_i(clk), .rst_i(rst), .bus(if0.slave));
  uart_tx_frame #(.Width(15), .DataWidth(8), .Parity(1), .StopBits(1))
    u1 (.clk_i(clk), .rst_i(rst), .bus(if1.slave));
  uart_tx_frame #(.Width(15), .DataWidth(8), .Parity(2), .StopBits(1))
    u2 (.clk_i(clk), .rst_i(rst), .bus(if2.slave));
  uart_tx_frame #(.Width(15), .DataWidth(8), .Parity(0), .StopBits(2))
    u3 (.clk_i(clk), .rst_i(rst), .bus(if3.slave));

  // Reference model: a frame is a list of bits, each lasting bd+1 cycles;
  // t counts cycles since the accepting edge.
  typedef struct {
    bit         act;
    int         t;
    logic [7:0] dat;
    int         bd;
    logic       tx;
    logic       busy;
    logic       done;
  } mdl_t;

  mdl_t m [4];

  function automatic int frame_len(int d, int bd);
    return (1 + 8 + ((PAR[d] != 0) ? 1 : 0) + STP[d]) * (bd + 1);
  endfunction

  function automatic logic level(int d, logic [7:0] dt, int bd, int t);
    int b;
    b = t / (bd + 1);
    if (b == 0) return 1'b0;
    if (b <= 8) return dt[b-1];
    if (b == 9 && PAR[d] != 0) return (^dt) ^ (PAR[d] == 2);
    return 1'b1;
  endfunction

  function automatic mdl_t mstep(mdl_t s, int d, logic r, logic st, logic [7:0] dt, int bd);
    mdl_t n;
    n = s;
    n.done = 1'b0;
    if (r) begin
      n.act = 1'b0;
      n.t = 0;
    end else begin
      if (n.act) begin
        n.t = n.t + 1;
        if (n.t == frame_len(d, n.bd)) begin
          n.done = 1'b1;
          n.act = 1'b0;
        end
      end
      if (!n.act && st) begin
        n.act = 1'b1;
        n.t = 0;
        n.dat = dt;
        n.bd = bd;
      end
    end
    n.busy = n.act;
    n.tx = n.act ? level(d, n.dat, n.bd, n.t) : 1'b1;
    return n;
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 4; d++) begin
      m[d] <= mstep(m[d], d, rst, start, data, int'(baud));
    end
  end

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      checks++;
      if ({tx_a[d], busy_a[d], done_a[d]} !== 3'b100) begin
        failures++;
        $display("FAIL reset dut%0d tx/busy/done got=%b%b%b exp=100", d, tx_a[d], busy_a[d], done_a[d]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_8n1();
    logic seq [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic etx;
    start = 1'b1; data = 8'hA5; baud = 15'd3;
    for (int c = 0; c <= 46; c++) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        checks++;
        if ({tx_a[d], busy_a[d], done_a[d]} !== {m[d].tx, m[d].busy, m[d].done}) begin
          failures++;
          $display("FAIL 8n1_model dut%0d c=%0d got=%b%b%b exp=%b%b%b", d, c,
                   tx_a[d], busy_a[d], done_a[d], m[d].tx, m[d].busy, m[d].done);
        end
      end
      etx = (c < 40) ? seq[c/4] : 1'b1;
      checks++;
      if (tx_a[0] !== etx) begin
        failures++; $display("FAIL 8n1_tx c=%0d got=%b exp=%b", c, tx_a[0], etx);
      end
      checks++;
      if (busy_a[0] !== (c < 40)) begin
        failures++; $display("FAIL 8n1_busy c=%0d got=%b exp=%b", c, busy_a[0], (c < 40));
      end
      checks++;
      if (done_a[0] !== (c == 40)) begin
        failures++; $display("FAIL 8n1_done c=%0d got=%b exp=%b", c, done_a[0], (c == 40));
      end
      if (c == 0) start = 1'b0;
    end
  endtask

  task automatic test_parity();
    start = 1'b1; data = 8'h07; baud = 15'd1;
    for (int c = 0; c <= 24; c++) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        checks++;
        if ({tx_a[d], busy_a[d], done_a[d]} !== {m[d].tx, m[d].busy, m[d].done}) begin
          failures++;
          $display("FAIL parity_model dut%0d c=%0d got=%b%b%b exp=%b%b%b", d, c,
                   tx_a[d], busy_a[d], done_a[d], m[d].tx, m[d].busy, m[d].done);
        end
      end
      if (c == 18 || c == 19) begin
        checks++;
        if (tx_a[1] !== 1'b1) begin
          failures++; $display("FAIL even_bit c=%0d got=%b exp=1", c, tx_a[1]);
        end
        checks++;
        if (tx_a[2] !== 1'b0) begin
          failures++; $display("FAIL odd_bit c=%0d got=%b exp=0", c, tx_a[2]);
        end
      end
      checks++;
      if (done_a[1] !== (c == 22)) begin
        failures++; $display("FAIL even_done c=%0d got=%b exp=%b", c, done_a[1], (c == 22));
      end
      if (c == 0) start = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic etx;
    start = 1'b1; data = 8'h01; baud = 15'd0;
    for (int c = 0; c <= 27; c++) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        checks++;
        if ({tx_a[d], busy_a[d], done_a[d]} !== {m[d].tx, m[d].busy, m[d].done}) begin
          failures++;
          $display("FAIL b2b_model dut%0d c=%0d got=%b%b%b exp=%b%b%b", d, c,
                   tx_a[d], busy_a[d], done_a[d], m[d].tx, m[d].busy, m[d].done);
        end
      end
      if (c <= 10 || (c >= 11 && c <= 18)) begin
        if (c == 0 || c == 10) etx = 1'b0;
        else if (c <= 8) etx = (c == 1);
        else etx = 1'b1;
        checks++;
        if (tx_a[0] !== etx) begin
          failures++; $display("FAIL b2b_tx c=%0d got=%b exp=%b", c, tx_a[0], etx);
        end
      end
      checks++;
      if (busy_a[0] !== (c < 20)) begin
        failures++; $display("FAIL b2b_busy c=%0d got=%b exp=%b", c, busy_a[0], (c < 20));
      end
      checks++;
      if (done_a[0] !== (c == 10 || c == 20)) begin
        failures++; $display("FAIL b2b_done c=%0d got=%b exp=%b", c, done_a[0], (c == 10 || c == 20));
      end
      if (c == 3) data = 8'hFF;
      if (c == 13) data = 8'h00;
      if (c == 15) start = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    start = 1'b1; data = 8'($urandom); baud = 15'd2;
    for (int c = 0; c <= 40; c++) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        checks++;
        if ({tx_a[d], busy_a[d], done_a[d]} !== {m[d].tx, m[d].busy, m[d].done}) begin
          failures++;
          $display("FAIL rstmid_model dut%0d c=%0d got=%b%b%b exp=%b%b%b", d, c,
                   tx_a[d], busy_a[d], done_a[d], m[d].tx, m[d].busy, m[d].done);
        end
        if (c >= 11) begin
          checks++;
          if ({tx_a[d], busy_a[d], done_a[d]} !== 3'b100) begin
            failures++;
            $display("FAIL rstmid_idle dut%0d c=%0d got=%b%b%b exp=100", d, c, tx_a[d], busy_a[d], done_a[d]);
          end
        end
      end
      if (c == 0) start = 1'b0;
      if (c == 10) rst = 1'b1;
      if (c == 11) rst = 1'b0;
    end
    start = 1'b1; data = 8'($urandom); baud = 15'd1;
    for (int c = 0; c <= 24; c++) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        checks++;
        if ({tx_a[d], busy_a[d], done_a[d]} !== {m[d].tx, m[d].busy, m[d].done}) begin
          failures++;
          $display("FAIL rstmid_after dut%0d c=%0d got=%b%b%b exp=%b%b%b", d, c,
                   tx_a[d], busy_a[d], done_a[d], m[d].tx, m[d].busy, m[d].done);
        end
      end
      checks++;
      if (done_a[0] !== (c == 20)) begin
        failures++; $display("FAIL rstmid_done c=%0d got=%b exp=%b", c, done_a[0], (c == 20));
      end
      if (c == 0) start = 1'b0;
    end
  endtask

  task automatic test_stop2();
    logic etx;
    start = 1'b1; data = 8'h00; baud = 15'd0;
    for (int c = 0; c <= 13; c++) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        checks++;
        if ({tx_a[d], busy_a[d], done_a[d]} !== {m[d].tx, m[d].busy, m[d].done}) begin
          failures++;
          $display("FAIL stop2_model dut%0d c=%0d got=%b%b%b exp=%b%b%b", d, c,
                   tx_a[d], busy_a[d], done_a[d], m[d].tx, m[d].busy, m[d].done);
        end
      end
      etx = (c >= 9);
      checks++;
      if (tx_a[3] !== etx) begin
        failures++; $display("FAIL stop2_tx c=%0d got=%b exp=%b", c, tx_a[3], etx);
      end
      checks++;
      if (done_a[3] !== (c == 11)) begin
        failures++; $display("FAIL stop2_done c=%0d got=%b exp=%b", c, done_a[3], (c == 11));
      end
      if (c == 0) start = 1'b0;
      if (c == 2) baud = 15'd5;
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 460; c++) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        checks++;
        if ({tx_a[d], busy_a[d], done_a[d]} !== {m[d].tx, m[d].busy, m[d].done}) begin
          failures++;
          $display("FAIL random_model dut%0d c=%0d got=%b%b%b exp=%b%b%b", d, c,
                   tx_a[d], busy_a[d], done_a[d], m[d].tx, m[d].busy, m[d].done);
        end
      end
      start = (c < 400) && ($urandom_range(0, 5) == 0);
      data  = 8'($urandom);
      baud  = 15'($urandom_range(0, 3));
      rst   = (c == 200);
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_back_to_back();
    test_reset_mid();
    test_stop2();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
